// File: rtl/aes_ctr_reg.sv
// aes_ctr_reg: counter-register responder for the AES CTR increment FSM.
// Holds the 128-bit CTR counter as NumSlices slices, turns a level req_i
// into a one-cycle-per-accept incr_o command, serves the indexed slice to the
// FSM, captures its write-backs in strict slice order, and flags protocol
// violations on incr_err_o / alert_o (terminal until reset).
// Optional build macro: AES_CTR_WRAP_DETECT_EN adds a sticky wrap_o flag.
module aes_ctr_reg #(
  parameter int SliceSizeCtr = 16,
  parameter int NumSlices    = 8,
  localparam int SliceIdxWidth = $clog2(NumSlices),
  localparam int CtrWidth      = SliceSizeCtr * NumSlices
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     ctr_load_i,
  input  logic [CtrWidth-1:0]      ctr_i,
  input  logic                     req_i,
  output logic                     ack_o,
  output logic [CtrWidth-1:0]      ctr_o,
  output logic                     incr_o,
  input  logic                     ready_i,
  input  logic [SliceIdxWidth-1:0] ctr_slice_idx_i,
  output logic [SliceSizeCtr-1:0]  ctr_slice_o,
  input  logic [SliceSizeCtr-1:0]  ctr_slice_i,
  input  logic                     ctr_we_i,
  output logic                     incr_err_o,
  output logic                     alert_o,
  output logic                     wrap_o
);

  // Sparse state codes, pairwise Hamming distance >= 3, so a single upset
  // never lands on another legal state; unused codes are treated as faults.
  typedef enum logic [5:0] {
    IDLE  = 6'b000111,
    ISSUE = 6'b011001,
    BUSY  = 6'b101010,
    DONE  = 6'b110100,
    ERROR = 6'b100001
  } state_e;

  localparam logic [SliceIdxWidth:0] WrCntMax = (SliceIdxWidth + 1)'(NumSlices);

  state_e                  state_reg, state_next;
  logic [CtrWidth-1:0]     ctr_reg, ctr_next, ctr_wr_data;
  logic [SliceIdxWidth:0]  wr_cnt_reg, wr_cnt_next;
  logic                    err_detect;
  logic                    incr_reg, ack_reg, alert_reg;
  logic [SliceSizeCtr-1:0] slice_rd [NumSlices];

  // Per-slice read view and write-merge; slice 0 is the least significant.
  for (genvar gi = 0; gi < NumSlices; gi++) begin : g_slice
    assign slice_rd[gi] = ctr_reg[gi*SliceSizeCtr +: SliceSizeCtr];
    assign ctr_wr_data[gi*SliceSizeCtr +: SliceSizeCtr] =
        (ctr_slice_idx_i == SliceIdxWidth'(gi)) ? ctr_slice_i
                                                : ctr_reg[gi*SliceSizeCtr +: SliceSizeCtr];
  end

  assign ctr_slice_o = slice_rd[ctr_slice_idx_i];

  // Protocol checker: flags a violation in the same cycle it is presented.
  always_comb begin
    err_detect = 1'b0;
    case (state_reg)
      IDLE, ISSUE, DONE: err_detect = ctr_we_i;
      BUSY: begin
        err_detect = (ctr_we_i && ((wr_cnt_reg == WrCntMax) ||
                                   ({1'b0, ctr_slice_idx_i} != wr_cnt_reg))) ||
                     (ready_i && (wr_cnt_reg < WrCntMax));
      end
      ERROR:   err_detect = 1'b0;
      default: err_detect = 1'b1;
    endcase
  end

  // Next-state and datapath update; a detected violation overrides everything.
  always_comb begin
    state_next  = state_reg;
    ctr_next    = ctr_reg;
    wr_cnt_next = wr_cnt_reg;
    if (err_detect) begin
      state_next = ERROR;
    end else begin
      case (state_reg)
        IDLE: begin
          // Load wins; a held req_i is picked up on the following cycle.
          if (ctr_load_i) begin
            ctr_next = ctr_i;
          end else if (req_i) begin
            state_next  = ISSUE;
            wr_cnt_next = '0;
          end
        end
        ISSUE: begin
          if (ready_i) state_next = BUSY;
        end
        BUSY: begin
          if (ctr_we_i) begin
            ctr_next    = ctr_wr_data;
            wr_cnt_next = wr_cnt_reg + 1'b1;
          end else if (ready_i) begin
            state_next = DONE;
          end
        end
        DONE:    state_next = IDLE;
        ERROR:   state_next = ERROR;
        default: state_next = ERROR;
      endcase
    end
  end

  // FSM state, counter and registered control outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg  <= IDLE;
      ctr_reg    <= '0;
      wr_cnt_reg <= '0;
      incr_reg   <= 1'b0;
      ack_reg    <= 1'b0;
      alert_reg  <= 1'b0;
    end else begin
      state_reg  <= state_next;
      ctr_reg    <= ctr_next;
      wr_cnt_reg <= wr_cnt_next;
      incr_reg   <= (state_next == ISSUE);
      ack_reg    <= (state_next == DONE);
      alert_reg  <= (state_next == ERROR);
    end
  end

  assign ctr_o      = ctr_reg;
  assign incr_o     = incr_reg;
  assign ack_o      = ack_reg;
  assign alert_o    = alert_reg;
  assign incr_err_o = err_detect | alert_reg;

`ifdef AES_CTR_WRAP_DETECT_EN
  logic wrap_reg, wrap_next;

  // Sticky wrap flag: set when a completed increment leaves the counter at 0.
  always_comb begin
    wrap_next = wrap_reg;
    if (!err_detect) begin
      if ((state_reg == IDLE) && ctr_load_i) begin
        wrap_next = 1'b0;
      end else if ((state_reg == DONE) && (ctr_reg == '0)) begin
        wrap_next = 1'b1;
      end
    end
  end

  // Wrap flag register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wrap_reg <= 1'b0;
    end else begin
      wrap_reg <= wrap_next;
    end
  end

  assign wrap_o = wrap_reg;
`else
  assign wrap_o = 1'b0;
`endif

endmodule

// File: tb/tb_aes_ctr_reg.sv
// tb_aes_ctr_reg: self-checking bench for aes_ctr_reg. The bench plays the
// cipher control (req/ack) and a conforming increment FSM that reads each
// slice and writes back slice+carry; expected counter values come from plain
// 128-bit arithmetic in a reference model and from a constant vector table.
module tb_aes_ctr_reg;

  localparam int NumSlices = 8;
`ifdef AES_CTR_WRAP_DETECT_EN
  localparam bit WrapEn = 1'b1;
`else
  localparam bit WrapEn = 1'b0;
`endif

  logic         clk, rst_n;
  logic         ctr_load, req, ready, we;
  logic [127:0] ctr_in;
  logic [2:0]   idx;
  logic [15:0]  slice_in;
  logic         ack, incr, incr_err, alert, wrap;
  logic [127:0] ctr_out;
  logic [15:0]  slice_out;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [127:0] model_ctr;
  bit           model_wrap;

  typedef struct {
    logic [127:0] iv;
    logic [127:0] exp;
    int           delay;
    bit           drop_req;
    bit           load_busy;
  } vec_t;

  vec_t tbl [6];

  aes_ctr_reg dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .ctr_load_i      (ctr_load),
    .ctr_i           (ctr_in),
    .req_i           (req),
    .ack_o           (ack),
    .ctr_o           (ctr_out),
    .incr_o          (incr),
    .ready_i         (ready),
    .ctr_slice_idx_i (idx),
    .ctr_slice_o     (slice_out),
    .ctr_slice_i     (slice_in),
    .ctr_we_i        (we),
    .incr_err_o      (incr_err),
    .alert_o         (alert),
    .wrap_o          (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0b required=%0b", name, act, exp);
    end
  endtask

  task automatic check128(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic quiet_inputs();
    ctr_load = 1'b0; req = 1'b0; ready = 1'b0; we = 1'b0;
    ctr_in = '0; idx = '0; slice_in = '0;
  endtask

  task automatic check_all_zero(input string tag);
    check1({tag, "_ack"}, ack, 1'b0);
    check1({tag, "_incr"}, incr, 1'b0);
    check1({tag, "_alert"}, alert, 1'b0);
    check1({tag, "_incr_err"}, incr_err, 1'b0);
    check1({tag, "_wrap"}, wrap, 1'b0);
    check128({tag, "_ctr"}, ctr_out, 128'd0);
  endtask

  // Assert reset mid-cycle, check reset values, release on a later negedge.
  task automatic do_reset(input string tag);
    @(negedge clk);
    quiet_inputs();
    rst_n = 1'b0;
    #1;
    check_all_zero(tag);
    @(negedge clk);
    rst_n = 1'b1;
    model_ctr  = '0;
    model_wrap = 1'b0;
    $display("txn reset %s", tag);
  endtask

  task automatic do_load(input logic [127:0] v);
    @(negedge clk);
    ctr_load = 1'b1;
    ctr_in   = v;
    @(posedge clk);
    @(negedge clk);
    ctr_load = 1'b0;
    #1;
    check128("load_ctr", ctr_out, v);
    check1("load_wrap_clear", wrap, 1'b0);
    model_ctr  = v;
    model_wrap = 1'b0;
    $display("txn load ctr=%h", v);
  endtask

  // Caller has req_i high; the next posedge is E0. Plays a conforming FSM.
  task automatic incr_body(input int delay, input bit drop_req, input bit load_busy,
                           input logic [127:0] exp_ctr, input string tag);
    int          e0;
    int          lat;
    bit          got;
    logic [16:0] sum;
    logic        carry;
    got = 1'b0;
    lat = -1;
    @(posedge clk);
    @(negedge clk);
    e0 = cyc;
    for (int k = 0; k <= delay; k++) begin
      if (k > 0) @(negedge clk);
      ready = (k == delay);
      #1;
      check1("incr_held", incr, 1'b1);
      check1("issue_no_err", incr_err, 1'b0);
      @(posedge clk);
    end
    carry = 1'b1;
    for (int s = 0; s < NumSlices; s++) begin
      @(negedge clk);
      ready = 1'b0;
      we    = 1'b1;
      idx   = 3'(s);
      if (drop_req && s == 2) req = 1'b0;
      if (load_busy && s == 4) begin
        ctr_load = 1'b1;
        ctr_in   = ~exp_ctr;
      end else begin
        ctr_load = 1'b0;
      end
      #1;
      sum      = {1'b0, slice_out} + {16'd0, carry};
      slice_in = sum[15:0];
      carry    = sum[16];
      #1;
      check1("write_no_err", incr_err, 1'b0);
      check1("busy_no_incr", incr, 1'b0);
      @(posedge clk);
    end
    @(negedge clk);
    we       = 1'b0;
    ctr_load = 1'b0;
    ready    = 1'b1;
    for (int w = 0; w < 4; w++) begin
      #1;
      if (ack) begin
        got = 1'b1;
        lat = cyc - e0;
        break;
      end
      @(negedge clk);
    end
    check1("ack_seen", got, 1'b1);
    if (got) check_int("ack_latency", lat, 10 + delay);
    req = 1'b0;
    @(negedge clk);
    #1;
    check1("ack_one_cycle", ack, 1'b0);
    check128("incr_ctr", ctr_out, exp_ctr);
    check1("done_no_err", incr_err, 1'b0);
    check1("done_no_alert", alert, 1'b0);
    $display("txn incr %s delay=%0d drop_req=%0b load_busy=%0b latency=%0d ctr=%h",
             tag, delay, drop_req, load_busy, lat, ctr_out);
  endtask

  task automatic after_incr(input logic [127:0] exp_ctr);
    model_ctr = exp_ctr;
    if (exp_ctr == '0) model_wrap = 1'b1;
    check1("wrap_flag", wrap, WrapEn & model_wrap);
  endtask

  initial begin : main
    logic [127:0] v, exp_v, mask, one;
    logic [16:0]  sum;
    logic         carry;
    int           oo_seq [3];
    int           sh;

    rst_n = 1'b0;
    quiet_inputs();
    model_ctr  = '0;
    model_wrap = 1'b0;
    oo_seq = '{0, 1, 3};

    tbl[0] = '{128'h0000_0000_0000_0000_0000_0000_0000_FFFF,
               128'h0000_0000_0000_0000_0000_0000_0001_0000, 0, 1'b0, 1'b0};
    tbl[1] = '{128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF,
               128'h0000_0000_0000_0000_0000_0000_0000_0000, 1, 1'b0, 1'b0};
    tbl[2] = '{128'h0000_0000_0000_0000_0000_0000_0000_0000,
               128'h0000_0000_0000_0000_0000_0000_0000_0001, 5, 1'b0, 1'b0};
    tbl[3] = '{128'h0000_0000_0000_0000_FFFF_FFFF_FFFF_FFFF,
               128'h0000_0000_0000_0001_0000_0000_0000_0000, 2, 1'b1, 1'b0};
    tbl[4] = '{128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210,
               128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3211, 0, 1'b0, 1'b1};
    tbl[5] = '{128'h7FFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF,
               128'h8000_0000_0000_0000_0000_0000_0000_0000, 3, 1'b1, 1'b1};

    do_reset("initial");

    // Table-driven increments.
    for (int i = 0; i < 6; i++) begin
      do_load(tbl[i].iv);
      @(negedge clk);
      req = 1'b1; ready = 1'b1;
      incr_body(tbl[i].delay, tbl[i].drop_req, tbl[i].load_busy, tbl[i].exp, "vec");
      after_incr(tbl[i].exp);
    end

    // Load and request in the same cycle: increment sees the loaded value.
    v = 128'h1111_2222_3333_4444_5555_6666_7777_FFFF;
    @(negedge clk);
    ctr_load = 1'b1; ctr_in = v; req = 1'b1; ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ctr_load = 1'b0;
    #1;
    check128("load_req_ctr", ctr_out, v);
    check1("load_req_no_incr", incr, 1'b0);
    model_ctr = v; model_wrap = 1'b0;
    exp_v = v + 128'd1;
    incr_body(0, 1'b0, 1'b0, exp_v, "load_and_req");
    after_incr(exp_v);

    // Randomised operations against the arithmetic model.
    one = 128'd1;
    for (int t = 0; t < 24; t++) begin
      if ($urandom_range(0, 2) == 0) begin
        v = {$urandom, $urandom, $urandom, $urandom};
        if ($urandom_range(0, 1) == 1) begin
          sh   = $urandom_range(1, 128);
          mask = (one << sh) - one;
          v    = v | mask;
        end
        do_load(v);
      end
      exp_v = model_ctr + 128'd1;
      @(negedge clk);
      req = 1'b1; ready = 1'b1;
      incr_body($urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                exp_v, "rnd");
      after_incr(exp_v);
    end

    // Out-of-order write (0,1,3): error flagged in the cycle idx 3 appears.
    do_reset("pre_oo");
    v = 128'hA5A5_5A5A_0F0F_F0F0_CAFE_BABE_1234_FFFF;
    do_load(v);
    @(negedge clk);
    req = 1'b1; ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ready = 1'b1;
    @(posedge clk);
    carry = 1'b1;
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      ready = 1'b0; we = 1'b1; idx = 3'(oo_seq[s]);
      #1;
      sum      = {1'b0, slice_out} + {16'd0, carry};
      slice_in = sum[15:0];
      carry    = sum[16];
      #1;
      check1(s == 2 ? "oo_err_now" : "oo_ok_write", incr_err, s == 2);
      check1("oo_alert_late", alert, 1'b0);
      @(posedge clk);
    end
    @(negedge clk);
    we = 1'b0;
    exp_v = {v[127:32], v[31:0] + 32'd1};
    for (int c = 0; c < 6; c++) begin
      #1;
      check1("err_alert", alert, 1'b1);
      check1("err_incr_err", incr_err, 1'b1);
      check1("err_no_ack", ack, 1'b0);
      check1("err_no_incr", incr, 1'b0);
      check128("err_ctr_frozen", ctr_out, exp_v);
      ctr_load = 1'($urandom_range(0, 1));
      ctr_in   = {$urandom, $urandom, $urandom, $urandom};
      we       = 1'($urandom_range(0, 1));
      idx      = 3'($urandom_range(0, 7));
      ready    = 1'($urandom_range(0, 1));
      req      = 1'b1;
      @(negedge clk);
    end
    $display("txn out_of_order ctr=%h alert=%0b", ctr_out, alert);
    do_reset("after_oo");

    // Write strobe while idle.
    v = {$urandom, $urandom, $urandom, $urandom};
    do_load(v);
    @(negedge clk);
    we = 1'b1; idx = 3'($urandom_range(0, 7)); slice_in = 16'($urandom);
    #1;
    check1("idle_we_err_now", incr_err, 1'b1);
    @(posedge clk);
    @(negedge clk);
    we = 1'b0;
    #1;
    check1("idle_we_alert", alert, 1'b1);
    check128("idle_we_ctr_kept", ctr_out, v);
    check1("idle_we_no_ack", ack, 1'b0);
    $display("txn idle_write ctr=%h alert=%0b", ctr_out, alert);
    do_reset("after_idle_we");

    // Reset in the middle of an operation.
    do_load(128'hDEAD_BEEF_0000_0000_0000_0000_0000_0042);
    @(negedge clk);
    req = 1'b1; ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    #1;
    check1("midop_incr", incr, 1'b1);
    rst_n = 1'b0;
    req   = 1'b0;
    #1;
    check_all_zero("midop_rst");
    @(negedge clk);
    rst_n = 1'b1;
    model_ctr = '0; model_wrap = 1'b0;
    $display("txn reset_mid_op");

    // After reset the counter increments from zero.
    @(negedge clk);
    req = 1'b1; ready = 1'b1;
    incr_body(0, 1'b0, 1'b0, 128'd1, "post_reset");
    after_incr(128'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/aes_ctr_reg.md
Name: aes_ctr_reg

Overview:
- Counter-register responder that sits opposite the AES CTR increment FSM.
- Holds the 128-bit CTR-mode counter as NumSlices slices and accepts increment requests from the cipher control via a req/ack handshake.
- On each request it issues a one-cycle incr to the FSM, serves the slice the FSM indexes, and captures the slice write-backs.
- Checks the write sequence for protocol violations and drives the FSM's incr_err input.

Parameters:
- SliceSizeCtr, 16, bits per counter slice.
- NumSlices, 8, number of slices; SliceSizeCtr*NumSlices = 128.
- SliceIdxWidth, 3, $clog2(NumSlices); derived, not overridden.

Ports:
- clk_i  in  1  clock; the only clock.
- rst_ni  in  1  reset; asynchronous, active-low.
- ctr_load_i  in  1  load ctr_i into the counter register.
- ctr_i  in  128  initial counter value (IV).
- req_i  in  1  increment request; level, held until ack_o.
- ack_o  out  1  one-cycle pulse; the increment has completed.
- ctr_o  out  128  current counter value.
- incr_o  out  1  increment command to the FSM.
- ready_i  in  1  FSM ready.
- ctr_slice_idx_i  in  SliceIdxWidth  slice index from the FSM.
- ctr_slice_o  out  SliceSizeCtr  ctr_q[idx*SliceSizeCtr +: SliceSizeCtr].
- ctr_slice_i  in  SliceSizeCtr  updated slice from the FSM.
- ctr_we_i  in  1  slice write enable from the FSM.
- incr_err_o  out  1  protocol error; feeds the FSM's incr_err_i.
- alert_o  out  1  terminal error indication.
- wrap_o  out  1  counter wrapped (optional feature).

Behaviour:
- Reset values: ctr_q = 0, state = IDLE, wr_cnt = 0; all outputs 0 except ctr_o = 0.
- Slice ordering: slice 0 is the LSB slice. ctr_slice_o is combinational from ctr_q and ctr_slice_idx_i.
- ctr_o = ctr_q in all states.
- IDLE:
  - ctr_load_i=1 → ctr_q <= ctr_i. Load has priority over req_i; req_i is serviced next cycle because it is level-held.
  - Else req_i=1 → ISSUE, wr_cnt <= 0.
- ISSUE:
  - incr_o=1.
  - ready_i=1 → BUSY; the FSM accepts on this edge.
  - ready_i=0 → hold incr_o.
- BUSY:
  - ctr_we_i=1 → ctr_q slice[ctr_slice_idx_i] <= ctr_slice_i; wr_cnt++.
  - Required write order is idx 0,1,…,NumSlices-1. Any idx != wr_cnt → error.
  - ready_i=1 && wr_cnt==NumSlices → DONE.
  - ready_i=1 && wr_cnt<NumSlices (premature completion) → error.
- DONE: ack_o=1 for one cycle → IDLE.
- ERROR:
  - Terminal state: alert_o=1, incr_err_o=1, incr_o=0, ack_o=0.
  - Loads, requests and writes are ignored.
  - Exit only via rst_ni.
- Error sources, all → ERROR on the next edge:
  - ctr_we_i=1 outside BUSY.
  - Out-of-order index.
  - wr_cnt overflow, i.e. a write when wr_cnt==NumSlices.
  - Premature completion.
  - Invalid state encoding.
- incr_err_o is asserted combinationally in the cycle the violation is detected, and stays high in ERROR.
- ctr_load_i outside IDLE is ignored with no error.
- req_i deasserted mid-operation: the operation completes and ack_o still pulses.
- Latency with a conforming FSM: req_i sampled at edge E0 → incr_o high E0..E1 → writes captured E2..E(NumSlices+1) → DONE after edge E(NumSlices+2). With defaults, ack_o is high in the cycle after E10.
- Wrap-around: 2^128-1 +1 = 0 with carry dropped; no error.
- Reset mid-operation: immediately returns to reset values, whatever the state.
- The state register uses sparse encoding with the codebase's sparse-FSM flop primitive.

Optional Feature:
- AES_CTR_WRAP_DETECT_EN defined:
  - wrap_o is a sticky flag, set in DONE when ctr_q==0 after the increment.
  - Cleared by ctr_load_i or reset.
- Undefined: wrap_o tied to 0; no extra flops.

Test Plan:
- Load ctr_i=0x...0000_FFFF, req_i=1, FSM model writes slices 0..7 in order → ctr_o=0x...0001_0000, one ack_o pulse 10 cycles after req_i sampled, incr_err_o never set.
- Load all-ones, increment → ctr_o=0, no error; with AES_CTR_WRAP_DETECT_EN wrap_o=1, cleared by the next load.
- FSM model writes idx 0,1,3 → incr_err_o=1 in the cycle idx 3 is presented, then alert_o=1 persistently, ack_o never asserted; rst_ni low → all outputs 0.
- ctr_we_i pulsed while IDLE → ERROR, alert_o=1, ctr_q unchanged.
- Hold ready_i=0 for 5 cycles in ISSUE → incr_o held high for all 5 cycles, then normal completion.
- ctr_load_i=1 and req_i=1 in the same cycle → load applied first, increment operates on the new value; ctr_load_i during BUSY → ignored.
